// File: rtl/unpacker.sv
// Receive-side stamp checker for the user data path, with its input FIFO and register block.
// Payload words carry a 32-bit stamp in [63:32], which is compared against the EXPECTED register.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef UNPACKER_REG_ADDR_WIDTH
`define UNPACKER_REG_ADDR_WIDTH 6
`endif
`ifndef UNPACKER_BLOCK_ADDR
`define UNPACKER_BLOCK_ADDR 17'h00021
`endif

// Small first-word-fallthrough FIFO: dout shows the head word whenever !empty.
// Latency: a write is visible on dout the cycle after wr_en.
// Backpressure: nearly_full asserts at depth-1; writing while full is not guarded.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);
  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_LVL   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      depth <= depth + 1'b1;
      else if (!wr_en && rd_en) depth <= depth - 1'b1;
    end
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (depth == '0);
  assign full        = (depth == FULL_LVL);
  assign nearly_full = (depth >= NF_LVL);
endmodule

// Register-ring block: software regs (read/write) then hardware regs (read-only) after the counters.
// Latency: one cycle from ring input to ring output.
// Backpressure: none; requests not addressed to this block pass through unchanged.
module generic_regs #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 6,
  parameter int NUM_COUNTERS      = 0,
  parameter int NUM_SOFTWARE_REGS = 1,
  parameter int NUM_HARDWARE_REGS = 1
) (
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,
  output logic [32*NUM_SOFTWARE_REGS-1:0]  software_regs,
  input  logic [32*NUM_HARDWARE_REGS-1:0]  hardware_regs,
  input  logic                             clk,
  input  logic                             reset
);
  localparam int TW = `UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [TW-1:0] TAG_BITS = TW'(TAG);

  logic [31:0]               sw_q [NUM_SOFTWARE_REGS];
  logic [REG_ADDR_WIDTH-1:0] off;
  logic                      hit;
  logic [31:0]               rd_val;

  assign off = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign hit = reg_req_in && !reg_ack_in &&
               (reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_BITS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_SOFTWARE_REGS; i++)
      if (off == REG_ADDR_WIDTH'(NUM_COUNTERS + i)) rd_val = sw_q[i];
    for (int i = 0; i < NUM_HARDWARE_REGS; i++)
      if (off == REG_ADDR_WIDTH'(NUM_COUNTERS + NUM_SOFTWARE_REGS + i))
        rd_val = hardware_regs[32*i +: 32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SOFTWARE_REGS; i++) sw_q[i] <= '0;
    end else if (hit && !reg_rd_wr_L_in) begin
      for (int i = 0; i < NUM_SOFTWARE_REGS; i++)
        if (off == REG_ADDR_WIDTH'(NUM_COUNTERS + i)) sw_q[i] <= reg_data_in;
    end
  end

  for (genvar g = 0; g < NUM_SOFTWARE_REGS; g++) begin : g_sw
    assign software_regs[32*g +: 32] = sw_q[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in || hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end
endmodule

// Stamp checker: counts checked/bad payload words and bad packets, optionally zeroes the stamp.
// Latency: 2 cycles in_wr -> out_wr (FIFO write, then output register).
// Backpressure: out_rdy low stalls the FIFO head; in_rdy drops at FIFO nearly_full.
module unpacker #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out
);
  typedef enum logic {HDRS, PAYLOAD} state_t;

  logic [CTRL_WIDTH-1:0] fifo_ctrl;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty, fifo_full, fifo_nearly_full;
  logic                  accept, is_payload;
  logic [31:0]           stamp;

  logic [63:0]  sw_regs;
  logic [127:0] hw_regs;
  logic [31:0]  expected;
  logic         check_en, strip, clear;
  logic         unused_ctrl_bits;

  state_t state, state_nxt;
  logic   pkt_bad, pkt_bad_nxt, pkt_bad_inc;
  logic   word_chk, word_bad;
  logic [31:0] words_checked, bad_words, bad_pkts, last_bad_stamp;

  fallthrough_small_fifo #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (accept),
    .dout        ({fifo_ctrl, fifo_data}),
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty),
    .reset       (reset),
    .clk         (clk)
  );

  assign in_rdy     = !fifo_nearly_full;
  assign accept     = !fifo_empty && out_rdy;
  assign is_payload = (fifo_ctrl == '0);
  assign stamp      = fifo_data[DATA_WIDTH-1 -: 32];

  assign expected         = sw_regs[31:0];
  assign check_en         = sw_regs[32];
  assign strip            = sw_regs[33];
  assign clear            = sw_regs[34];
  assign unused_ctrl_bits = ^sw_regs[63:35];

  assign word_chk = accept && is_payload && check_en;
  assign word_bad = word_chk && (stamp != expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HDRS;
      pkt_bad <= 1'b0;
    end else begin
      state   <= state_nxt;
      pkt_bad <= pkt_bad_nxt;
    end
  end

  // The first payload word's mismatch must win over the start-of-payload clear.
  always_comb begin
    state_nxt   = state;
    pkt_bad_nxt = pkt_bad;
    pkt_bad_inc = 1'b0;
    if (accept) begin
      case (state)
        HDRS: if (is_payload) begin
          state_nxt = PAYLOAD;
          if (check_en) pkt_bad_nxt = 1'b0;
        end
        PAYLOAD: if (!is_payload) begin
          state_nxt   = HDRS;
          pkt_bad_inc = check_en && pkt_bad;
        end
        default: state_nxt = HDRS;
      endcase
    end
    if (word_bad) pkt_bad_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      words_checked  <= '0;
      bad_words      <= '0;
      bad_pkts       <= '0;
      last_bad_stamp <= '0;
    end else begin
      if (word_chk) words_checked <= words_checked + 32'd1;
      if (word_bad) begin
        bad_words      <= bad_words + 32'd1;
        last_bad_stamp <= stamp;
      end
      if (pkt_bad_inc) bad_pkts <= bad_pkts + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= accept;
      if (accept) begin
        out_ctrl <= fifo_ctrl;
        out_data <= (strip && is_payload) ? {32'd0, fifo_data[DATA_WIDTH-33:0]} : fifo_data;
      end
    end
  end

  assign hw_regs = {last_bad_stamp, bad_pkts, bad_words, words_checked};

  generic_regs #(
    .UDP_REG_SRC_WIDTH (UDP_REG_SRC_WIDTH),
    .TAG               (`UNPACKER_BLOCK_ADDR),
    .REG_ADDR_WIDTH    (`UNPACKER_REG_ADDR_WIDTH),
    .NUM_COUNTERS      (0),
    .NUM_SOFTWARE_REGS (2),
    .NUM_HARDWARE_REGS (4)
  ) u_regs (
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .software_regs   (sw_regs),
    .hardware_regs   (hw_regs),
    .clk             (clk),
    .reset           (reset)
  );

  a_no_write_when_full: assert property (@(posedge clk) disable iff (reset) !(in_wr && fifo_full));
endmodule

// File: tb/tb_unpacker.sv
// Directed bench for unpacker: scoreboarded forwarding plus register-ring reads of the counters.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef UNPACKER_REG_ADDR_WIDTH
`define UNPACKER_REG_ADDR_WIDTH 6
`endif
`ifndef UNPACKER_BLOCK_ADDR
`define UNPACKER_BLOCK_ADDR 17'h00021
`endif

module tb_unpacker;
  localparam int AW        = `UDP_REG_ADDR_WIDTH;
  localparam int BASE_ADDR = `UNPACKER_BLOCK_ADDR << `UNPACKER_REG_ADDR_WIDTH;
  localparam int R_EXP = 0, R_CTRL = 1, R_WORDS = 2, R_BADW = 3, R_BADP = 4, R_LAST = 5;
  localparam logic [31:0] GOOD = 32'hA5A5_0001;

  logic        clk, reset;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, out_wr, out_rdy;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_in, reg_addr_out;
  logic [31:0] reg_data_in, reg_data_out;
  logic [1:0]  reg_src_in, reg_src_out;

  int n_cmp = 0;
  int n_bad = 0;
  int pkt_no = 0;
  logic [71:0] exp_q [$];

  unpacker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .UDP_REG_SRC_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every forwarded word must match the head of the expected queue, in order.
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      check("fwd_avail", 72'(exp_q.size() > 0), 72'd1);
      if (exp_q.size() > 0) check("fwd_word", {out_ctrl, out_data}, exp_q.pop_front());
    end
  end

  task automatic send_word(input logic [7:0] c, input logic [63:0] d, input logic [63:0] e);
    int t = 0;
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) check("in_rdy_timeout", 72'(in_rdy), 72'd1);
    else begin
      in_ctrl = c;
      in_data = d;
      in_wr   = 1'b1;
      exp_q.push_back({c, e});
      @(negedge clk);
      in_wr = 1'b0;
    end
  endtask

  task automatic send_body(input logic [31:0] s0, s1, s2, s3);
    logic [31:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++)
      send_word(8'h00, {s[i], 16'(pkt_no), 16'(i)}, {s[i], 16'(pkt_no), 16'(i)});
    send_word(8'h01, {32'hE0E0_0000, 16'(pkt_no), 16'hFFFF}, {32'hE0E0_0000, 16'(pkt_no), 16'hFFFF});
    pkt_no++;
  endtask

  task automatic send_pkt(input logic [31:0] s0, s1, s2, s3);
    send_word(8'hFF, {32'hC0DE_0000, 16'(pkt_no), 16'h0000}, {32'hC0DE_0000, 16'(pkt_no), 16'h0000});
    send_body(s0, s1, s2, s3);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 72'(exp_q.size()), 72'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reg_acc(input logic rd, input int off, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int t = 0;
    logic [AW-1:0] a;
    a = AW'(BASE_ADDR + off);
    reg_req_in     = 1'b1;
    reg_rd_wr_L_in = rd;
    reg_addr_in    = a;
    reg_data_in    = wdat;
    @(negedge clk);
    reg_req_in = 1'b0;
    while (!reg_ack_out && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("reg_ack", 72'(reg_ack_out), 72'd1);
    check("ring_pass", 72'({reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_src_out}),
          72'({1'b1, rd, a, 2'b10}));
    rdat = reg_data_out;
    @(negedge clk);
  endtask

  task automatic reg_wr(input int off, input logic [31:0] v);
    logic [31:0] dummy;
    reg_acc(1'b0, off, v, dummy);
  endtask

  task automatic reg_chk(input string tag, input int off, input logic [31:0] exp);
    logic [31:0] r;
    reg_acc(1'b1, off, 32'h0, r);
    check(tag, 72'(r), 72'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = 2'b10;
    repeat (3) @(negedge clk);
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", 72'(in_rdy), 72'd1);
    reg_chk("rst_words", R_WORDS, 32'd0);
    reg_chk("rst_badw", R_BADW, 32'd0);
    reg_chk("rst_badp", R_BADP, 32'd0);
    reg_chk("rst_last", R_LAST, 32'd0);
    reg_chk("rst_expected", R_EXP, 32'd0);
    reg_chk("rst_ctrl", R_CTRL, 32'd0);

    // Match: three good packets, first header used to measure latency.
    reg_wr(R_EXP, GOOD);
    reg_wr(R_CTRL, 32'h1);
    send_word(8'hFF, 64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0000);
    check("lat_cycle1", 72'(out_wr), 72'd0);
    @(negedge clk);
    check("lat_cycle2", 72'(out_wr), 72'd1);
    send_body(GOOD, GOOD, GOOD, GOOD);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    drain();
    reg_chk("match_words", R_WORDS, 32'd12);
    reg_chk("match_badw", R_BADW, 32'd0);
    reg_chk("match_badp", R_BADP, 32'd0);

    // Mismatch: bad word mid-packet, then bad first payload word, then a good packet.
    reg_wr(R_CTRL, 32'h5);
    reg_wr(R_CTRL, 32'h1);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    send_pkt(GOOD, GOOD, 32'hDEAD_BEEF, GOOD);
    drain();
    reg_chk("mis_badw_1", R_BADW, 32'd1);
    reg_chk("mis_badp_1", R_BADP, 32'd1);
    reg_chk("mis_last_1", R_LAST, 32'hDEAD_BEEF);
    send_pkt(32'h0BAD_0003, GOOD, GOOD, GOOD);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    drain();
    reg_chk("mis_words", R_WORDS, 32'd16);
    reg_chk("mis_badw_2", R_BADW, 32'd2);
    reg_chk("mis_badp_2", R_BADP, 32'd2);
    reg_chk("mis_last_2", R_LAST, 32'h0BAD_0003);

    // Strip: only payload words lose [63:32]; checking still sees the original stamp.
    reg_wr(R_CTRL, 32'h3);
    send_word(8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    send_word(8'h00, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_9ABC_DEF0);
    send_word(8'h00, 64'hA5A5_0001_5555_0000, 64'h0000_0000_5555_0000);
    send_word(8'h01, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);
    drain();
    reg_chk("strip_badw", R_BADW, 32'd3);
    reg_chk("strip_last", R_LAST, 32'h1234_5678);

    // Backpressure: stall from the 9th negedge; words 0..7 (5 payload) were accepted before it.
    reg_wr(R_CTRL, 32'h5);
    reg_wr(R_CTRL, 32'h1);
    fork
      begin
        for (int p = 0; p < 3; p++) send_pkt(GOOD, GOOD, GOOD, GOOD);
      end
      begin
        repeat (9) @(negedge clk);
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        reg_chk("bp_words_a", R_WORDS, 32'd5);
        repeat (2) @(negedge clk);
        check("bp_in_rdy", 72'(in_rdy), 72'd0);
        reg_chk("bp_words_b", R_WORDS, 32'd5);
        out_rdy = 1'b1;
      end
    join
    drain();
    reg_chk("bp_words", R_WORDS, 32'd12);
    reg_chk("bp_badw", R_BADW, 32'd0);
    reg_chk("bp_badp", R_BADP, 32'd0);

    // Clear holds everything at zero; disable freezes counters but still forwards.
    reg_wr(R_CTRL, 32'h4);
    send_pkt(32'hDEAD_0001, GOOD, 32'hDEAD_0002, GOOD);
    drain();
    reg_chk("clr_words", R_WORDS, 32'd0);
    reg_chk("clr_badw", R_BADW, 32'd0);
    reg_chk("clr_badp", R_BADP, 32'd0);
    reg_chk("clr_last", R_LAST, 32'd0);
    reg_wr(R_CTRL, 32'h1);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    drain();
    reg_wr(R_CTRL, 32'h0);
    send_pkt(32'hDEAD_0003, GOOD, GOOD, GOOD);
    drain();
    reg_chk("dis_words", R_WORDS, 32'd4);
    reg_chk("dis_badw", R_BADW, 32'd0);
    reg_chk("dis_badp", R_BADP, 32'd0);

    // Reset after two payload words, then a clean packet.
    reg_wr(R_CTRL, 32'h1);
    send_word(8'hFF, 64'hC0DE_0000_7777_0000, 64'hC0DE_0000_7777_0000);
    send_word(8'h00, 64'hBAD0_0001_7777_0001, 64'hBAD0_0001_7777_0001);
    send_word(8'h00, 64'hBAD0_0002_7777_0002, 64'hBAD0_0002_7777_0002);
    drain();
    reset = 1'b1;
    @(negedge clk);
    check("mrst_out_wr", 72'(out_wr), 72'd0);
    check("mrst_out_data", 72'(out_data), 72'd0);
    check("mrst_out_ctrl", 72'(out_ctrl), 72'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reg_wr(R_EXP, GOOD);
    reg_wr(R_CTRL, 32'h1);
    send_pkt(GOOD, GOOD, GOOD, GOOD);
    drain();
    reg_chk("mrst_words", R_WORDS, 32'd4);
    reg_chk("mrst_badw", R_BADW, 32'd0);
    reg_chk("mrst_badp", R_BADP, 32'd0);

    check("final_queue", 72'(exp_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/unpacker.md
# unpacker

Receive-side counterpart of the stamping stage in the user data path. Checks, on every payload word (ctrl == 0) of every packet, that bits [63:32] carry the 32-bit stamp the transmitter inserted. Mismatches are counted per word and per packet. The stamp field can optionally be zeroed before the word is forwarded. Sits between the input arbiter side of the user data path and the output port lookup, with the standard NetFPGA module-header / payload framing and the standard register ring.

## Interface
Parameters:
- DATA_WIDTH, 64, data bus width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width
- UDP_REG_SRC_WIDTH, 2, register source tag width

Ports (all synchronous to clk):
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  upstream data word
- in_ctrl  in  CTRL_WIDTH  upstream ctrl byte
- in_wr  in  1  upstream write strobe
- in_rdy  out  1  ready to upstream; = !input FIFO nearly_full
- out_data  out  DATA_WIDTH  downstream data word, registered
- out_ctrl  out  CTRL_WIDTH  downstream ctrl byte, registered
- out_wr  out  1  downstream write strobe, registered
- out_rdy  in  1  downstream ready
- reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  register ring
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  register ring
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  register ring
- reg_src_in  in  UDP_REG_SRC_WIDTH  register ring
- reg_*_out  out  same widths  register ring pass-through/response

## Operation
- Input buffering: fallthrough_small_fifo, width CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS 2.
- Registers: generic_regs, TAG `UNPACKER_BLOCK_ADDR, REG_ADDR_WIDTH `UNPACKER_REG_ADDR_WIDTH, 0 counters.
- Software registers (2):
  - sw0 EXPECTED: expected stamp.
  - sw1 CTRL: bit0 CHECK_EN; bit1 STRIP (zero [63:32] on forwarded payload words); bit2 CLEAR (while 1, all hardware registers are held at 0).
- Hardware registers (4, 32-bit):
  - hw0 WORDS_CHECKED
  - hw1 BAD_WORDS
  - hw2 BAD_PKTS
  - hw3 LAST_BAD_STAMP: value of [63:32] from the most recent bad word.
- Counters wrap modulo 2^32.
- Word transfer: a word is accepted when FIFO !empty && out_rdy. On accept, rd_en = 1 and the output registers load the word; out_wr = 1 on the next cycle. Otherwise out_wr = 0 on the next cycle.
- STRIP is applied only to words with ctrl == 0. out_ctrl is never modified.
- FSM, 2 states, advanced only on accepted words:
  - HDRS: ctrl != 0 stays in HDRS. ctrl == 0 goes to PAYLOAD and clears pkt_bad.
  - PAYLOAD: ctrl == 0 stays. ctrl != 0 is the EOP word: return to HDRS; if pkt_bad, BAD_PKTS += 1.
- Check, on each accepted word with ctrl == 0 and CHECK_EN = 1:
  - WORDS_CHECKED += 1.
  - If data[63:32] != EXPECTED: BAD_WORDS += 1, LAST_BAD_STAMP <= data[63:32], pkt_bad <= 1.
  - The EOP word (ctrl != 0) is not checked.
- The first payload word updates counters and sets pkt_bad. The pkt_bad clear on HDRS→PAYLOAD must not mask that first word's mismatch.
- CHECK_EN = 0: no counter or pkt_bad updates; forwarding and STRIP are unaffected.
- Simultaneous CLEAR and an update: CLEAR wins.
- EXPECTED/CTRL writes take effect for words accepted on the cycle after the register write completes.

## Timing
- Reset values: out_wr 0, out_data 0, out_ctrl 0, FSM HDRS, pkt_bad 0, all hardware registers 0, all software registers 0. in_rdy is 1 one cycle after reset deasserts (FIFO empty).
- Latency: in_wr to out_wr is 2 cycles when the FIFO is empty and out_rdy = 1 (FIFO write, then output register).
- Throughput: one word per cycle while out_rdy stays high.
- out_rdy low: no accept and no FSM/counter change. The FIFO fills; in_rdy drops at nearly_full, leaving 1 word of slack. A word written while full is a protocol violation and is not handled.
- Reset mid-packet: the FSM returns to HDRS and the FIFO empties. The next accepted word is treated as a header until ctrl == 0 is seen.
- Register ring latency is as defined by generic_regs.

## Test plan
- Match: EXPECTED = 0xA5A5_0001, CHECK_EN = 1. Send 3 packets, each 1 header (ctrl 0xFF) + 4 payload words stamped 0xA5A5_0001 + EOP (ctrl 0x01) -> WORDS_CHECKED 12, BAD_WORDS 0, BAD_PKTS 0; output identical to input, 2-cycle latency.
- Mismatch: same traffic, packet 2 word 3 stamped 0xDEAD_BEEF -> BAD_WORDS 1, BAD_PKTS 1, LAST_BAD_STAMP 0xDEAD_BEEF. A mismatch on the first payload word of packet 3 -> BAD_PKTS 2.
- Strip: CTRL = 0x3, payload 0x1234_5678_9ABC_DEF0 -> out_data 0x0000_0000_9ABC_DEF0. Header and EOP words are forwarded unchanged.
- Backpressure: hold out_rdy = 0 for 10 cycles mid-packet while streaming -> in_rdy drops; no words lost or duplicated; counters are unchanged during the stall; final counts match the no-stall run.
- Clear/disable: CTRL = 0x4 -> all hardware registers read 0 even with traffic. CTRL = 0x0 -> counters frozen, data still forwarded.
- Reset mid-packet after 2 payload words, then a full good packet -> outputs 0 during reset, WORDS_CHECKED 4 afterward, no spurious BAD_PKTS.
